// File: rtl/cart_mem_pkg.sv
// cart_mem_pkg: shared types and helpers for the virtual cartridge store
// Contents: loader state enum, flags bit index of the CHR-RAM switch,
// and the byte-offset to ROM lane-enable helper.
package cart_mem_pkg;
    typedef enum logic [1:0] {LOAD, SETTLE, READY} cart_state_t;
    localparam int FLAGS_CHRAM_BIT = 15;
    function automatic logic [3:0] lane_mask(input logic [1:0] byte_ofs);
        return 4'b0001 << byte_ofs;
    endfunction
endpackage

// File: rtl/cart_word_ram.sv
// cart_word_ram: WORDS x 32 single-port synchronous RAM, byte-lane write mask, registered read
// Ports: clock; addr word index; wmask lane write enables (bit0 = bits 7:0);
//        wdata write word; rdata word read at the previous edge (old data on same-address write).
module cart_word_ram #(
    parameter int WORDS = 32768,
    localparam int AW = $clog2(WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wmask,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] mem [WORDS];
    always_ff @(posedge clock) begin
        rdata <= mem[addr];
        for (int i = 0; i < 4; i++)
            if (wmask[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
endmodule

// File: rtl/cart_mem_gen.sv
// cart_mem_gen: virtual NES cartridge store loaded from flash, serving PRG/CHR/cart-RAM byte access
// Ports: clock, reset (sync active-high); reload/index restart the load from slot index;
//        cart_ready, flags_out, csum_err load status; address, prg_sel, chr_sel, ram_sel,
//        rden, wren, write_data, read_data host byte bus (1-cycle read latency);
//        fm_valid, fm_ready, fm_addr, fm_rdata word-wide flash reader handshake.
// Build option: define CART_MEM_CSUM_EN to fetch and verify a trailing checksum word.
module cart_mem_gen
    import cart_mem_pkg::*;
#(
    parameter int          ROM_WORDS     = 32768,
    parameter int          CHR_BASE_WORD = 16384,
    parameter int          RAM_BYTES     = 4096,
    parameter logic [23:0] FLASH_BASE    = 24'h100000,
    parameter int          SLOT_SHIFT    = 18,
    parameter int          SLOT_BITS     = 4,
    parameter int          SETTLE_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 reload,
    input  logic [SLOT_BITS-1:0] index,
    output logic                 cart_ready,
    output logic [31:0]          flags_out,
    output logic                 csum_err,
    input  logic [20:0]          address,
    input  logic                 prg_sel,
    input  logic                 chr_sel,
    input  logic                 ram_sel,
    input  logic                 rden,
    input  logic                 wren,
    input  logic [7:0]           write_data,
    output logic [7:0]           read_data,
    output logic                 fm_valid,
    input  logic                 fm_ready,
    output logic [23:0]          fm_addr,
    input  logic [31:0]          fm_rdata
);
    localparam int WA  = $clog2(ROM_WORDS);
    localparam int LW  = WA + 1;
    localparam int RBW = WA + 2;
    localparam int CA  = $clog2(RAM_BYTES);
    localparam int SW  = $clog2(SETTLE_CYCLES + 1);
`ifdef CART_MEM_CSUM_EN
    localparam logic [LW-1:0] LAST_WORD = LW'(ROM_WORDS + 1);
`else
    localparam logic [LW-1:0] LAST_WORD = LW'(ROM_WORDS);
`endif
    cart_state_t          state, state_nxt;
    logic [LW-1:0]        load_addr;
    logic [SLOT_BITS-1:0] index_lat;
    logic [SW-1:0]        settle_cnt;
    logic                 take, img_take;
    logic                 rom_hit, ram_hit;
    logic [RBW-1:0]       rom_byte;
    logic [CA-1:0]        ram_byte;
    logic [WA-1:0]        wr_addr;
    logic [3:0]           wr_mask;
    logic [31:0]          wr_data, rom_q;
    logic [7:0]           cram [RAM_BYTES];
    logic [7:0]           cram_q, hold_q;
    logic                 src_rom, src_ram;
    logic [1:0]           lane_q;
    logic                 unused_ok;
    // rden only gates power upstream, and address bits above the region widths fold away
    assign unused_ok = &{1'b0, rden, address};
    // A flash word coincident with reload is dropped
    assign take     = fm_valid && fm_ready && !reload;
    assign img_take = take && load_addr < LW'(ROM_WORDS);
    assign fm_addr  = FLASH_BASE + (24'(index_lat) << SLOT_SHIFT) + (24'(load_addr) << 2);
    always_ff @(posedge clock)
        state <= (reset || reload) ? LOAD : state_nxt;
    always_comb
        state_nxt = (take && load_addr == LAST_WORD) ? SETTLE :
                    (state == SETTLE && settle_cnt == SW'(SETTLE_CYCLES - 1)) ? READY : state;
    always_comb begin
        fm_valid   = state == LOAD;
        cart_ready = state == READY;
    end
    always_ff @(posedge clock) begin
        if (reset || reload) begin
            load_addr  <= '0;
            index_lat  <= reset ? '0 : index;
            flags_out  <= '0;
            settle_cnt <= '0;
        end else begin
            if (take) load_addr <= load_addr + 1'b1;
            if (take && load_addr == LW'(ROM_WORDS)) flags_out <= fm_rdata;
            if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
        end
    end
`ifdef CART_MEM_CSUM_EN
    logic [31:0] csum;
    always_ff @(posedge clock) begin
        if (reset || reload) begin
            csum     <= '0;
            csum_err <= 1'b0;
        end else if (img_take) begin
            csum <= csum + fm_rdata;
        end else if (take && load_addr == LAST_WORD) begin
            csum_err <= csum != fm_rdata;
        end
    end
`else
    assign csum_err = 1'b0;
`endif
    // Select priority chr > prg > ram; CHR follows the CHR-RAM flag
    always_comb begin
        rom_hit  = cart_ready && (chr_sel ? !flags_out[FLAGS_CHRAM_BIT] : prg_sel);
        ram_hit  = cart_ready && (chr_sel ? flags_out[FLAGS_CHRAM_BIT] : !prg_sel && ram_sel);
        rom_byte = chr_sel ? RBW'(address) + RBW'(CHR_BASE_WORD * 4) : RBW'(address);
        ram_byte = CA'(address);
    end
    // The loader owns the single word port until the image is in place
    always_comb begin
        wr_addr = (state == LOAD) ? load_addr[WA-1:0] : rom_byte[RBW-1:2];
        wr_mask = img_take ? 4'hF : (rom_hit && wren) ? lane_mask(rom_byte[1:0]) : 4'h0;
        wr_data = img_take ? fm_rdata : {4{write_data}};
    end
    cart_word_ram #(.WORDS(ROM_WORDS)) u_rom (
        .clock (clock),
        .addr  (wr_addr),
        .wmask (wr_mask),
        .wdata (wr_data),
        .rdata (rom_q)
    );
    always_ff @(posedge clock) begin
        cram_q <= cram[ram_byte];
        if (ram_hit && wren) cram[ram_byte] <= write_data;
    end
    // hold_q keeps the last presented byte so read_data holds while nothing is selected
    always_ff @(posedge clock) begin
        if (reset || reload) begin
            src_rom <= 1'b0;
            src_ram <= 1'b0;
            lane_q  <= '0;
            hold_q  <= '0;
        end else begin
            src_rom <= rom_hit;
            src_ram <= ram_hit;
            lane_q  <= rom_byte[1:0];
            hold_q  <= read_data;
        end
    end
    always_comb
        read_data = src_rom ? rom_q[8*lane_q +: 8] : src_ram ? cram_q : hold_q;
endmodule

// File: tb/tb_cart_mem_gen.sv
// tb_cart_mem_gen: randomized self-checking bench for cart_mem_gen against a byte-level model
module tb_cart_mem_gen;
    localparam int RW = 16, CB = 8, RB = 4096, SC = 4;
`ifdef CART_MEM_CSUM_EN
    localparam int NW = RW + 2;
`else
    localparam int NW = RW + 1;
`endif
    logic        clock = 1'b0;
    logic        reset, reload, cart_ready, csum_err;
    logic [3:0]  index;
    logic [31:0] flags_out, fm_rdata;
    logic [20:0] address;
    logic        prg_sel, chr_sel, ram_sel, rden, wren, fm_valid, fm_ready;
    logic [7:0]  write_data, read_data;
    logic [23:0] fm_addr;
    always #5 clock = ~clock;
    cart_mem_gen #(
        .ROM_WORDS(RW), .CHR_BASE_WORD(CB), .RAM_BYTES(RB), .SETTLE_CYCLES(SC)
    ) dut (
        .clock(clock), .reset(reset), .reload(reload), .index(index),
        .cart_ready(cart_ready), .flags_out(flags_out), .csum_err(csum_err),
        .address(address), .prg_sel(prg_sel), .chr_sel(chr_sel), .ram_sel(ram_sel),
        .rden(rden), .wren(wren), .write_data(write_data), .read_data(read_data),
        .fm_valid(fm_valid), .fm_ready(fm_ready), .fm_addr(fm_addr), .fm_rdata(fm_rdata)
    );
    int          checks = 0, fails = 0;
    logic [31:0] img [NW];
    logic [31:0] rom_m [RW];
    logic [7:0]  ram_m [RB];
    bit          ram_known [RB];
    logic [31:0] cur_flags;
    logic [7:0]  exp_rd;
    bit          exp_ok;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] img_sum();
        logic [31:0] s = 0;
        for (int i = 0; i < RW; i++) s += img[i];
        return s;
    endfunction
    function automatic logic [31:0] exp_err();
`ifdef CART_MEM_CSUM_EN
        return {31'b0, img_sum() != img[RW+1]};
`else
        return 0;
`endif
    endfunction
    task automatic set_tail(input logic [31:0] flags, input logic [31:0] ck);
        img[RW] = flags;
`ifdef CART_MEM_CSUM_EN
        img[RW+1] = ck;
`else
        if (ck == 32'hFFFF_FFFF) img[RW] = flags;
`endif
        cur_flags = flags;
    endtask
    task automatic do_reload(input logic [3:0] slot);
        reload = 1; index = slot;
        @(negedge clock);
        reload = 0;
    endtask
    task automatic feed(input int slot, input int first, input int last);
        for (int w = first; w < last; w++) begin
            check("fm_valid", fm_valid, 1);
            check("fm_addr", fm_addr, (32'h100000 + (slot << 18) + w * 4) & 32'hFFFFFF);
            repeat (2) @(negedge clock);
            fm_ready = 1; fm_rdata = img[w];
            @(negedge clock);
            fm_ready = 0;
        end
    endtask
    task automatic settle();
        check("flags", flags_out, cur_flags);
        check("ready_n0", cart_ready, 0);
        check("valid_off", fm_valid, 0);
        prg_sel = 1; wren = 1; address = 0; write_data = ~img[0][7:0];
        for (int k = 1; k < SC; k++) begin
            @(negedge clock);
            prg_sel = 0; wren = 0;
            check("ready_early", cart_ready, 0);
            check("rd_gated", read_data, 0);
        end
        @(negedge clock);
        check("ready_rise", cart_ready, 1);
        check("csum_err", csum_err, exp_err());
        for (int i = 0; i < RW; i++) rom_m[i] = img[i];
        exp_rd = 0; exp_ok = 1;
    endtask
    task automatic host(input bit c, input bit p, input bit r, input logic [20:0] a,
                        input bit we, input logic [7:0] wd, input string tag);
        int b;
        chr_sel = c; prg_sel = p; ram_sel = r; address = a; wren = we;
        write_data = wd; rden = c | p | r;
        if (c ? !cur_flags[15] : p) begin
            b = c ? (CB * 4 + int'(a)) % (RW * 4) : int'(a) % (RW * 4);
            exp_rd = rom_m[b / 4][8 * (b % 4) +: 8]; exp_ok = 1;
            if (we) rom_m[b / 4][8 * (b % 4) +: 8] = wd;
        end else if (c || r) begin
            b = int'(a) % RB;
            exp_rd = ram_m[b]; exp_ok = ram_known[b];
            if (we) begin ram_m[b] = wd; ram_known[b] = 1; end
        end
        @(negedge clock);
        if (exp_ok) check(tag, read_data, exp_rd);
    endtask
    task automatic rand_ops(input int n);
        for (int i = 0; i < n; i++)
            host($urandom % 4 == 0, $urandom % 3 == 0, $urandom % 2 == 1,
                 21'($urandom) & 21'h1FF03F, $urandom % 3 == 0, 8'($urandom), "rand_rd");
        chr_sel = 0; prg_sel = 0; ram_sel = 0; wren = 0; rden = 0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        int slot;
        reset = 1; reload = 0; index = 0; fm_ready = 0; fm_rdata = 0;
        prg_sel = 0; chr_sel = 0; ram_sel = 0; rden = 0; wren = 0;
        address = 0; write_data = 0; exp_rd = 0; exp_ok = 0; cur_flags = 0;
        repeat (2) @(negedge clock);
        reset = 0;
        check("rst_ready", cart_ready, 0);
        check("rst_flags", flags_out, 0);
        check("rst_csum", csum_err, 0);
        check("rst_rd", read_data, 0);
        // Load 1: words 1..16, CHR-RAM flags, matching checksum
        for (int i = 0; i < RW; i++) img[i] = i + 1;
        set_tail(32'h0000_8001, 32'd136);
        feed(0, 0, NW);
        settle();
        host(0, 1, 0, 21'd0, 0, 8'h00, "gate_rom");
        host(1, 0, 0, 21'h1003, 1, 8'h5A, "chr_ram_wr");
        host(0, 0, 1, 21'd3, 0, 8'h00, "chr_ram_rd");
        check("chr_ram_5a", read_data, 32'h5A);
        host(0, 0, 0, 21'd0, 0, 8'h00, "hold");
        // Load 2: aborted at word 5 by a reload to slot 2, bad checksum
        do_reload(0);
        check("rl_ready", cart_ready, 0);
        check("rl_rd", read_data, 0);
        set_tail(32'h0000_0001, 32'd137);
        feed(0, 0, 5);
        repeat (2) @(negedge clock);
        fm_ready = 1; fm_rdata = 32'hDEAD_BEEF; reload = 1; index = 2;
        @(negedge clock);
        fm_ready = 0; reload = 0;
        check("slot_addr", fm_addr, 32'h180000);
        feed(2, 0, NW);
        settle();
        host(1, 0, 0, 21'd0, 0, 8'h00, "chr_rom");
        check("chr_rom_w8", read_data, 32'h9);
        rand_ops(200);
        // Load 3: random slot, image and flags; lane order checks
        slot = $urandom % 16;
        for (int i = 0; i < RW; i++) img[i] = $urandom;
        img[3] = 32'hDDCC_BBAA;
        set_tail({$urandom} ^ 32'h8000 * ($urandom % 2), ($urandom % 2) ? img_sum() : $urandom);
        do_reload(4'(slot));
        feed(slot, 0, NW);
        settle();
        for (int a = 12; a < 16; a++) host(0, 1, 0, 21'(a), 0, 8'h00, "lane_rd");
        check("lane_dd", read_data, 32'hDD);
        rand_ops(300);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
